// File: rtl/lift8_if.sv
// Signal bundle between the lift controller and its environment: calls and
// safety inputs in, cabin/door status and the request bitmap out.
interface lift8_if;
  logic [2:0] req_floor;
  logic       ir_blocked;
  logic       overload;
  logic       emergency_stop;
  logic       door;
  logic [2:0] current_floor;
  logic [7:0] requests;
  logic [2:0] max_request;
  logic [2:0] min_request;
  logic       Up;
  logic       Down;
  logic       idle;
  logic       overload_warn;
  logic [2:0] fsm_state;

  // Environment side drives calls and sensors; controller side drives status.
  // There is no valid/ready handshake: req_floor is sampled every clock and a
  // change of value between two edges is taken as one new call.
  modport master (
    output req_floor, ir_blocked, overload, emergency_stop,
    input  door, current_floor, requests, max_request, min_request,
    input  Up, Down, idle, overload_warn, fsm_state
  );

  modport slave (
    input  req_floor, ir_blocked, overload, emergency_stop,
    output door, current_floor, requests, max_request, min_request,
    output Up, Down, idle, overload_warn, fsm_state
  );
endinterface

// File: rtl/lift8.sv
// Eight-floor lift controller: captures floor calls into a bitmap, sweeps the
// cabin one floor per clock, and holds the door open for DOOR_CYCLES clocks.
module lift8 #(
  parameter int DOOR_CYCLES = 3
) (
  input logic   clk,
  input logic   reset,
  lift8_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR_OPEN = 3'd3,
    EMERGENCY = 3'd4
  } state_t;

  localparam int CW = (DOOR_CYCLES < 1) ? 1 : $clog2(DOOR_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DOOR_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state;
  logic [2:0]    current_floor;
  logic [7:0]    requests;
  logic [2:0]    prev_req;
  logic [CW-1:0] door_cnt;
  logic          dir_up;
  logic          door_q;
  logic          up_q;
  logic          down_q;
  logic          idle_q;

  logic       new_call;
  logic [7:0] set_mask;
  logic [7:0] cur_bit;
  logic [7:0] above_mask;
  logic [7:0] below_mask;
  logic       req_above;
  logic       req_below;
  logic [2:0] next_up;
  logic [2:0] next_down;
  logic       door_hold;
  logic [2:0] max_r;
  logic [2:0] min_r;

  assign new_call   = (bus.req_floor != prev_req);
  assign set_mask   = new_call ? (8'd1 << bus.req_floor) : 8'd0;
  assign cur_bit    = 8'd1 << current_floor;
  assign above_mask = (8'hFF << current_floor) & ~cur_bit;
  assign below_mask = ~(8'hFF << current_floor);
  assign req_above  = |(requests & above_mask);
  assign req_below  = |(requests & below_mask);
  assign next_up    = current_floor + 3'd1;
  assign next_down  = current_floor - 3'd1;
  // A fresh call for the floor we are standing at restarts the door timer.
  assign door_hold  = bus.ir_blocked | bus.overload |
                      (new_call && (bus.req_floor == current_floor));

  always_comb begin
    max_r = 3'd0;
    min_r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (requests[i]) max_r = 3'(i);
    end
    for (int i = 7; i >= 0; i--) begin
      if (requests[i]) min_r = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      current_floor <= 3'd0;
      requests      <= 8'd0;
      prev_req      <= 3'd0;
      door_cnt      <= '0;
      dir_up        <= 1'b1;
      door_q        <= 1'b0;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      prev_req <= bus.req_floor;
      requests <= requests | set_mask;
      if (bus.emergency_stop) begin
        state    <= EMERGENCY;
        door_q   <= 1'b0;
        up_q     <= 1'b0;
        down_q   <= 1'b0;
        idle_q   <= 1'b0;
        door_cnt <= '0;
      end else begin
        case (state)
          EMERGENCY: begin
            state  <= IDLE;
            idle_q <= 1'b1;
          end
          IDLE: begin
            if (requests[current_floor]) begin
              requests <= (requests | set_mask) & ~cur_bit;
              state    <= DOOR_OPEN;
              door_q   <= 1'b1;
              idle_q   <= 1'b0;
              door_cnt <= CNT_LOAD;
            end else if ((requests != 8'd0) && !bus.overload) begin
              idle_q <= 1'b0;
              if (req_above) begin
                state  <= MOVE_UP;
                up_q   <= 1'b1;
                dir_up <= 1'b1;
              end else begin
                state  <= MOVE_DOWN;
                down_q <= 1'b1;
                dir_up <= 1'b0;
              end
            end
          end
          MOVE_UP: begin
            if (current_floor == 3'd7) begin
              state  <= IDLE;
              up_q   <= 1'b0;
              idle_q <= 1'b1;
            end else begin
              current_floor <= next_up;
              if (requests[next_up]) begin
                requests <= (requests | set_mask) & ~(8'd1 << next_up);
                state    <= DOOR_OPEN;
                up_q     <= 1'b0;
                door_q   <= 1'b1;
                door_cnt <= CNT_LOAD;
              end
            end
          end
          MOVE_DOWN: begin
            if (current_floor == 3'd0) begin
              state  <= IDLE;
              down_q <= 1'b0;
              idle_q <= 1'b1;
            end else begin
              current_floor <= next_down;
              if (requests[next_down]) begin
                requests <= (requests | set_mask) & ~(8'd1 << next_down);
                state    <= DOOR_OPEN;
                down_q   <= 1'b0;
                door_q   <= 1'b1;
                door_cnt <= CNT_LOAD;
              end
            end
          end
          DOOR_OPEN: begin
            requests <= (requests | set_mask) & ~cur_bit;
            if (door_hold) begin
              door_cnt <= CNT_LOAD;
            end else if (door_cnt > CNT_ONE) begin
              door_cnt <= door_cnt - CNT_ONE;
            end else begin
              door_q   <= 1'b0;
              door_cnt <= '0;
              // Keep sweeping the same way while calls remain ahead.
              if (dir_up && req_above) begin
                state <= MOVE_UP;
                up_q  <= 1'b1;
              end else if (!dir_up && req_below) begin
                state  <= MOVE_DOWN;
                down_q <= 1'b1;
              end else if (req_above) begin
                state  <= MOVE_UP;
                up_q   <= 1'b1;
                dir_up <= 1'b1;
              end else if (req_below) begin
                state  <= MOVE_DOWN;
                down_q <= 1'b1;
                dir_up <= 1'b0;
              end else begin
                state  <= IDLE;
                idle_q <= 1'b1;
              end
            end
          end
          default: begin
            state    <= IDLE;
            door_q   <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            idle_q   <= 1'b1;
            door_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.door          = door_q;
  assign bus.current_floor = current_floor;
  assign bus.requests      = requests;
  assign bus.max_request   = max_r;
  assign bus.min_request   = min_r;
  assign bus.Up            = up_q;
  assign bus.Down          = down_q;
  assign bus.idle          = idle_q;
  assign bus.overload_warn = bus.overload;
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_lift8.sv
// Bench for lift8: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural lift model.
module tb_lift8;
  localparam int DC = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lift8_if bus();

  lift8 #(.DOOR_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: cabin position, pending set, travel direction as
  // -1/0/+1 and remaining door-open clocks.
  int       m_floor = 0;
  int       m_prev = 0;
  int       m_dir = 0;
  int       m_door_left = 0;
  bit       m_estop = 1'b0;
  bit       m_last_up = 1'b1;
  bit [7:0] m_pend = 8'd0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int hi_bit(input bit [7:0] p);
    int r = 0;
    for (int f = 0; f < 8; f++) if (p[f]) r = f;
    return r;
  endfunction

  function automatic int lo_bit(input bit [7:0] p);
    int r = 0;
    for (int f = 7; f >= 0; f--) if (p[f]) r = f;
    return r;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_prev = 0; m_dir = 0; m_door_left = 0;
    m_estop = 1'b0; m_last_up = 1'b1; m_pend = 8'd0;
  endtask

  task automatic model_step();
    bit [7:0] old;
    bit       nc;
    bit       above;
    bit       below;
    int       rq;
    old = m_pend;
    rq = int'(bus.req_floor);
    nc = (rq != m_prev);
    m_prev = rq;
    above = 1'b0;
    below = 1'b0;
    for (int f = 0; f < 8; f++) begin
      if (old[f] && f > m_floor) above = 1'b1;
      if (old[f] && f < m_floor) below = 1'b1;
    end
    if (nc) m_pend[rq] = 1'b1;
    if (bus.emergency_stop) begin
      m_estop = 1'b1; m_dir = 0; m_door_left = 0;
    end else if (m_estop) begin
      m_estop = 1'b0;
    end else if (m_door_left > 0) begin
      m_pend[m_floor] = 1'b0;
      if (bus.ir_blocked || bus.overload || (nc && rq == m_floor)) m_door_left = DC;
      else if (m_door_left > 1) m_door_left--;
      else begin
        m_door_left = 0;
        if (m_last_up && above) m_dir = 1;
        else if (!m_last_up && below) m_dir = -1;
        else if (above) begin m_dir = 1; m_last_up = 1'b1; end
        else if (below) begin m_dir = -1; m_last_up = 1'b0; end
        else m_dir = 0;
      end
    end else if (m_dir != 0) begin
      if ((m_dir == 1 && m_floor == 7) || (m_dir == -1 && m_floor == 0)) m_dir = 0;
      else begin
        m_floor += m_dir;
        if (old[m_floor]) begin
          m_pend[m_floor] = 1'b0; m_dir = 0; m_door_left = DC;
        end
      end
    end else begin
      if (old[m_floor]) begin
        m_pend[m_floor] = 1'b0; m_door_left = DC;
      end else if (old != 8'd0 && !bus.overload) begin
        if (above) begin m_dir = 1; m_last_up = 1'b1; end
        else begin m_dir = -1; m_last_up = 1'b0; end
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("door", bus.door, 32'(m_door_left > 0));
      check("floor", bus.current_floor, 32'(m_floor));
      check("requests", bus.requests, 32'(m_pend));
      check("max_request", bus.max_request, 32'(hi_bit(m_pend)));
      check("min_request", bus.min_request, 32'(lo_bit(m_pend)));
      check("up", bus.Up, 32'(m_dir == 1));
      check("down", bus.Down, 32'(m_dir == -1));
      check("idle", bus.idle, 32'(!m_estop && m_dir == 0 && m_door_left == 0));
      check("overload_warn", bus.overload_warn, 32'(bus.overload));
      check("up_down_excl", bus.Up & bus.Down, 0);
      check("door_while_moving", bus.door & (bus.Up | bus.Down), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_door(input logic v, input int budget, input string nm);
    int n = 0;
    while (bus.door !== v && n < budget) begin
      step();
      n++;
    end
    check(nm, bus.door, v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_floor = 3'd0;
    bus.ir_blocked = 1'b0;
    bus.overload = 1'b0;
    bus.emergency_stop = 1'b0;
    repeat (3) step();
    check("reset_floor", bus.current_floor, 0);
    check("reset_idle", bus.idle, 1);
    reset = 1'b1;
    chk_en = 1'b1;

    // Held request value 0 after reset is not a call.
    step();
    check("no_call_after_reset", bus.requests, 8'h00);
    bus.req_floor = 3'd3;
    step();
    check("call3_req", bus.requests, 8'h08);
    check("call3_max", bus.max_request, 3);
    step();
    check("call3_up", bus.Up, 1);
    step();
    check("call3_f1", bus.current_floor, 1);
    step();
    check("call3_f2", bus.current_floor, 2);
    step();
    check("call3_f3", bus.current_floor, 3);
    check("call3_door", bus.door, 1);
    check("call3_clear", bus.requests, 8'h00);
    step();
    step();
    check("door_2nd_cycle", bus.door, 1);
    step();
    check("door_closed", bus.door, 0);
    check("idle_after_3", bus.idle, 1);

    // Up to the top floor, then a call back down to floor 1.
    bus.req_floor = 3'd7;
    step();
    check("call7_req", bus.requests, 8'h80);
    wait_door(1'b1, 20, "reach7_door");
    check("reach7_floor", bus.current_floor, 7);
    wait_door(1'b0, 10, "leave7_door");
    check("idle_at7", bus.idle, 1);
    bus.req_floor = 3'd1;
    step();
    check("call1_req", bus.requests, 8'h02);
    step();
    check("call1_down", bus.Down, 1);
    check("call1_from7", bus.current_floor, 7);
    wait_door(1'b1, 20, "reach1_door");
    check("reach1_floor", bus.current_floor, 1);

    // Overload keeps the door open; it then closes DC cycles after the drop.
    bus.overload = 1'b1;
    repeat (5) step();
    check("ovl_door", bus.door, 1);
    check("ovl_warn", bus.overload_warn, 1);
    check("ovl_floor", bus.current_floor, 1);
    bus.overload = 1'b0;
    n = 0;
    while (bus.door === 1'b1 && n < 10) begin
      n++;
      step();
    end
    check("ovl_release_cycles", n, DC);
    check("idle_at1", bus.idle, 1);
    check("empty_at1", bus.requests, 8'h00);

    // Emergency stop during an upward trip, with a call taken while stopped.
    bus.req_floor = 3'd6;
    repeat (4) step();
    check("pre_estop_floor", bus.current_floor, 3);
    bus.emergency_stop = 1'b1;
    bus.req_floor = 3'd2;
    step();
    check("estop_up", bus.Up, 0);
    check("estop_idle", bus.idle, 0);
    check("estop_reqs", bus.requests, 8'h44);
    step();
    check("estop_frozen", bus.current_floor, 3);
    bus.emergency_stop = 1'b0;
    step();
    check("estop_release_idle", bus.idle, 1);
    wait_door(1'b1, 20, "resume6_door");
    check("resume6_floor", bus.current_floor, 6);
    wait_door(1'b0, 10, "leave6_door");
    wait_door(1'b1, 20, "resume2_door");
    check("resume2_floor", bus.current_floor, 2);
    wait_door(1'b0, 10, "leave2_door");
    check("served_all", bus.requests, 8'h00);

    // Asynchronous reset in the middle of a trip.
    bus.req_floor = 3'd5;
    repeat (3) step();
    check("prereset_up", bus.Up, 1);
    #2;
    reset = 1'b0;
    bus.req_floor = 3'd0;
    #1;
    check("areset_floor", bus.current_floor, 0);
    check("areset_up", bus.Up, 0);
    check("areset_reqs", bus.requests, 8'h00);
    check("areset_idle", bus.idle, 1);
    check("areset_door", bus.door, 0);
    step();
    reset = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) bus.req_floor = 3'($urandom_range(0, 7));
      bus.ir_blocked = ($urandom_range(0, 11) == 0);
      bus.overload = ($urandom_range(0, 11) == 0);
      bus.emergency_stop = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
    end
    bus.ir_blocked = 1'b0;
    bus.overload = 1'b0;
    bus.emergency_stop = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
